pixel_aer_rr_arbiter: RTL and testbench

//  Parametrised successor to the fixed 3-level pixel hierarchy. Serves a ROWS x COLS pixel array.

---
 rtl/pixel_aer_rr_arbiter.sv | 164 ++++++++++++++++
 tb/tb_pixel_aer_rr_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_aer_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pixel_aer_rr_arbiter
// Brief    : Round-robin AER arbiter for a ROWS x COLS pixel array feeding a
//            first-word-fall-through FIFO on a valid/ready stream.
//            Optional macro PIXEL_DROP_CNT_EN enables the dropped-event counter.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_aer_rr_arbiter #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int POL_W = 2,
    parameter int TS_W  = 16,
    parameter int DEPTH = 4
) (
    input  logic                                           clk_i,
    input  logic                                           reset_n_i,
    input  logic [ROWS-1:0][COLS-1:0][POL_W-1:0]           set_i,
    output logic [ROWS-1:0][COLS-1:0]                      gnt_o,
    output logic [$clog2(ROWS)+$clog2(COLS)+TS_W+POL_W-1:0] data_o,
    output logic                                           valid_o,
    input  logic                                           ready_i,
    output logic                                           active_o,
    output logic                                           full_o,
    output logic [15:0]                                    drop_cnt_o
);

    localparam int c_RA    = $clog2(ROWS);
    localparam int c_CA    = $clog2(COLS);
    localparam int c_WIDTH = c_RA + c_CA + TS_W + POL_W;
    localparam int c_NPIX  = ROWS * COLS;
    localparam int c_IW    = $clog2(c_NPIX);
    localparam int c_PW    = $clog2(DEPTH);
    localparam int c_CW    = $clog2(DEPTH + 1);

    logic [c_NPIX-1:0]            w_set;
    logic [c_NPIX-1:0][POL_W-1:0] w_pol_in;
    logic [c_NPIX-1:0]            r_pending;
    logic [c_NPIX-1:0][POL_W-1:0] r_pol;
    logic [c_IW-1:0]              r_last_idx;
    logic [c_NPIX-1:0]            r_gnt;
    logic [TS_W-1:0]              r_ts;
    logic [c_WIDTH-1:0]           r_mem [DEPTH];
    logic [c_PW-1:0]              r_wr_ptr;
    logic [c_PW-1:0]              r_rd_ptr;
    logic [c_CW-1:0]              r_count;

    logic                         w_found;
    logic [c_IW-1:0]              w_win_idx;
    logic [c_IW:0]                w_probe;
    logic [c_RA-1:0]              w_win_row;
    logic [c_CA-1:0]              w_win_col;
    logic [c_NPIX-1:0]            w_win_onehot;
    logic                         w_full;
    logic                         w_valid;
    logic                         w_push;
    logic                         w_pop;

    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        for (genvar gc = 0; gc < COLS; gc++) begin : g_col
            assign w_pol_in[gr*COLS+gc] = set_i[gr][gc];
            assign w_set[gr*COLS+gc]    = |set_i[gr][gc];
        end
    end

    // Walk the flat index space starting just after the last winner.
    always_comb begin
        w_found   = 1'b0;
        w_win_idx = '0;
        w_probe   = '0;
        for (int k = 1; k <= c_NPIX; k++) begin
            w_probe = {1'b0, r_last_idx} + (c_IW+1)'(k);
            if (w_probe >= (c_IW+1)'(c_NPIX))
                w_probe = w_probe - (c_IW+1)'(c_NPIX);
            if (!w_found && r_pending[w_probe[c_IW-1:0]]) begin
                w_found   = 1'b1;
                w_win_idx = w_probe[c_IW-1:0];
            end
        end
    end

    assign w_full       = (r_count == c_CW'(DEPTH));
    assign w_valid      = (r_count != '0);
    assign w_push       = w_found && !w_full;
    assign w_pop        = w_valid && ready_i;
    assign w_win_onehot = w_push ? (c_NPIX'(1) << w_win_idx) : '0;
    assign w_win_row    = c_RA'(w_win_idx / c_IW'(COLS));
    assign w_win_col    = c_CA'(w_win_idx % c_IW'(COLS));

    function automatic logic [c_PW-1:0] f_ptr_next(input logic [c_PW-1:0] p);
        return (p == c_PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_pending  <= '0;
            r_pol      <= '0;
            r_last_idx <= c_IW'(c_NPIX - 1);
            r_gnt      <= '0;
            r_ts       <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            r_ts  <= r_ts + 1'b1;
            r_gnt <= w_win_onehot;
            // A pixel being granted this edge accepts a new event immediately.
            for (int i = 0; i < c_NPIX; i++) begin
                if (w_set[i] && (!r_pending[i] || w_win_onehot[i])) begin
                    r_pending[i] <= 1'b1;
                    r_pol[i]     <= w_pol_in[i];
                end else if (w_win_onehot[i]) begin
                    r_pending[i] <= 1'b0;
                end
            end
            if (w_push) begin
                r_last_idx      <= w_win_idx;
                r_mem[r_wr_ptr] <= {w_win_row, w_win_col, r_ts, r_pol[w_win_idx]};
                r_wr_ptr        <= f_ptr_next(r_wr_ptr);
            end
            if (w_pop)
                r_rd_ptr <= f_ptr_next(r_rd_ptr);
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
        end
    end

    assign gnt_o    = r_gnt;
    assign data_o   = w_valid ? r_mem[r_rd_ptr] : '0;
    assign valid_o  = w_valid;
    assign full_o   = w_full;
    assign active_o = (|r_pending) || w_valid;

`ifdef PIXEL_DROP_CNT_EN
    logic [c_NPIX-1:0] w_drop;
    logic [16:0]       w_drop_sum;
    logic [15:0]       r_drop_cnt;

    assign w_drop = w_set & r_pending & ~w_win_onehot;

    always_comb begin
        w_drop_sum = {1'b0, r_drop_cnt};
        for (int i = 0; i < c_NPIX; i++)
            w_drop_sum = w_drop_sum + 17'(w_drop[i]);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i)
            r_drop_cnt <= '0;
        else
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end

    assign drop_cnt_o = r_drop_cnt;
`else
    assign drop_cnt_o = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pixel_aer_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_aer_rr_arbiter
// Brief    : Directed, table-driven bench for pixel_aer_rr_arbiter (8x8, TS_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_aer_rr_arbiter;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int POL_W = 2;
    localparam int TS_W  = 4;
    localparam int DEPTH = 4;
    localparam int WIDTH = 3 + 3 + TS_W + POL_W;
`ifdef PIXEL_DROP_CNT_EN
    localparam logic [15:0] c_EXP_DROP = 16'd3;
`else
    localparam logic [15:0] c_EXP_DROP = 16'd0;
`endif

    logic                                 clk;
    logic                                 reset_n;
    logic [ROWS-1:0][COLS-1:0][POL_W-1:0] set_in;
    logic [ROWS-1:0][COLS-1:0]            gnt;
    logic [WIDTH-1:0]                     data;
    logic                                 valid;
    logic                                 ready;
    logic                                 active;
    logic                                 full;
    logic [15:0]                          drop_cnt;

    pixel_aer_rr_arbiter #(
        .ROWS (ROWS),
        .COLS (COLS),
        .POL_W(POL_W),
        .TS_W (TS_W),
        .DEPTH(DEPTH)
    ) u_dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .set_i     (set_in),
        .gnt_o     (gnt),
        .data_o    (data),
        .valid_o   (valid),
        .ready_i   (ready),
        .active_o  (active),
        .full_o    (full),
        .drop_cnt_o(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent timestamp model: zero on a reset edge, +1 on every other edge.
    logic [TS_W-1:0] ts_model;
    always @(posedge clk) begin
        if (!reset_n) ts_model <= '0;
        else          ts_model <= ts_model + 1'b1;
    end

    typedef struct {
        logic [2:0]  row;
        logic [2:0]  col;
        logic [1:0]  pol;
        logic [63:0] exp_gnt;
        logic [5:0]  exp_xy;
    } vec_t;

    vec_t             vecs [5];
    int               n_checks;
    int               n_pass;
    logic [WIDTH-1:0] got [8];
    int               n_got;
    logic [TS_W-1:0]  head_ts;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic set_pix(input int idx, input logic [1:0] pol);
        logic [2:0] r;
        logic [2:0] c;
        r = 3'(idx / COLS);
        c = 3'(idx % COLS);
        set_in[r][c] = pol;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        set_in  = '0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Checks a freshly granted event that is also the FIFO head this cycle.
    task automatic expect_grant(input string name, input logic [63:0] exp_gnt,
                                input logic [5:0] xy, input logic [1:0] pol);
        logic [TS_W-1:0] ts;
        ts = ts_model - 1'b1;
        check({name, "_gnt"},   64'(gnt),   exp_gnt);
        check({name, "_valid"}, 64'(valid), 64'd1);
        check({name, "_data"},  64'(data),  64'({xy, ts, pol}));
    endtask

    task automatic collect();
        ready = 1'b1;
        n_got = 0;
        for (int t = 0; t < 20; t++) begin
            if (valid) begin
                if (n_got < 8) got[n_got] = data;
                n_got++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        vecs[0] = '{row: 3'd2, col: 3'd5, pol: 2'b01, exp_gnt: 64'h0000_0000_0020_0000, exp_xy: 6'o25};
        vecs[1] = '{row: 3'd0, col: 3'd0, pol: 2'b10, exp_gnt: 64'h0000_0000_0000_0001, exp_xy: 6'o00};
        vecs[2] = '{row: 3'd7, col: 3'd7, pol: 2'b11, exp_gnt: 64'h8000_0000_0000_0000, exp_xy: 6'o77};
        vecs[3] = '{row: 3'd3, col: 3'd0, pol: 2'b01, exp_gnt: 64'h0000_0000_0100_0000, exp_xy: 6'o30};
        vecs[4] = '{row: 3'd5, col: 3'd6, pol: 2'b10, exp_gnt: 64'h0000_4000_0000_0000, exp_xy: 6'o56};

        // Reset held for three edges with every pixel requesting.
        reset_n = 1'b0;
        ready   = 1'b1;
        set_in  = '1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_gnt",    64'(gnt),      64'd0);
            check("rst_valid",  64'(valid),    64'd0);
            check("rst_active", 64'(active),   64'd0);
            check("rst_drop",   64'(drop_cnt), 64'd0);
        end
        check("rst_full", 64'(full), 64'd0);
        check("rst_data", 64'(data), 64'd0);
        reset_n = 1'b1;
        set_in  = '0;

        // Single-event vectors, ready held high.
        for (int i = 0; i < 5; i++) begin
            set_in[vecs[i].row][vecs[i].col] = vecs[i].pol;
            @(negedge clk);
            set_in = '0;
            check("vec_pre_gnt", 64'(gnt), 64'd0);
            @(negedge clk);
            expect_grant("vec", vecs[i].exp_gnt, vecs[i].exp_xy, vecs[i].pol);
            @(negedge clk);
            check("vec_post_gnt",   64'(gnt),   64'd0);
            check("vec_post_valid", 64'(valid), 64'd0);
        end

        // Round robin: 0, 9, 63 together, then 0 and 9 again.
        do_reset();
        set_pix(0, 2'b01); set_pix(9, 2'b01); set_pix(63, 2'b01);
        @(negedge clk);
        set_in = '0;
        @(negedge clk); expect_grant("rr0",  64'h1,                   6'o00, 2'b01);
        @(negedge clk); expect_grant("rr9",  64'h200,                 6'o11, 2'b01);
        @(negedge clk); expect_grant("rr63", 64'h8000_0000_0000_0000, 6'o77, 2'b01);
        @(negedge clk);
        check("rr_idle_gnt",   64'(gnt),   64'd0);
        check("rr_idle_valid", 64'(valid), 64'd0);
        set_pix(0, 2'b10); set_pix(9, 2'b10);
        @(negedge clk);
        set_in = '0;
        @(negedge clk); expect_grant("rr2_0", 64'h1,   6'o00, 2'b10);
        @(negedge clk); expect_grant("rr2_9", 64'h200, 6'o11, 2'b10);

        // Backpressure: six events into a four-deep FIFO.
        @(negedge clk);
        ready = 1'b0;
        set_pix(10, 2'b01); set_pix(20, 2'b01); set_pix(30, 2'b01);
        set_pix(40, 2'b01); set_pix(50, 2'b01); set_pix(60, 2'b01);
        @(negedge clk);
        set_in = '0;
        @(negedge clk);
        head_ts = ts_model - 1'b1;
        check("bp_gnt10", 64'(gnt), 64'h400);
        @(negedge clk); check("bp_gnt20", 64'(gnt), 64'h10_0000);
        @(negedge clk); check("bp_gnt30", 64'(gnt), 64'h4000_0000);
        @(negedge clk); check("bp_gnt40", 64'(gnt), 64'h0000_0100_0000_0000);
        check("bp_full", 64'(full), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_gnt",    64'(gnt),    64'd0);
            check("bp_hold_full",   64'(full),   64'd1);
            check("bp_hold_active", 64'(active), 64'd1);
            check("bp_hold_data",   64'(data),   64'({6'o12, head_ts, 2'b01}));
        end
        collect();
        check("bp_count", 64'(n_got), 64'd6);
        check("bp_ord0", 64'(got[0][WIDTH-1:WIDTH-6]), 64'(6'o12));
        check("bp_ord1", 64'(got[1][WIDTH-1:WIDTH-6]), 64'(6'o24));
        check("bp_ord2", 64'(got[2][WIDTH-1:WIDTH-6]), 64'(6'o36));
        check("bp_ord3", 64'(got[3][WIDTH-1:WIDTH-6]), 64'(6'o50));
        check("bp_ord4", 64'(got[4][WIDTH-1:WIDTH-6]), 64'(6'o62));
        check("bp_ord5", 64'(got[5][WIDTH-1:WIDTH-6]), 64'(6'o74));
        check("bp_drained_active", 64'(active), 64'd0);

        // Drops: pixel 7 pending behind a full FIFO, re-requested three times.
        do_reset();
        ready = 1'b0;
        set_pix(1, 2'b11); set_pix(2, 2'b11); set_pix(3, 2'b11); set_pix(4, 2'b11);
        set_pix(7, 2'b01);
        @(negedge clk);
        set_in = '0;
        repeat (4) @(negedge clk);
        check("drop_full", 64'(full), 64'd1);
        check("drop_before", 64'(drop_cnt), 64'd0);
        set_pix(7, 2'b10);
        repeat (3) @(negedge clk);
        set_in = '0;
        check("drop_cnt", 64'(drop_cnt), 64'(c_EXP_DROP));
        @(negedge clk);
        check("drop_cnt_hold", 64'(drop_cnt), 64'(c_EXP_DROP));
        collect();
        check("drop_count", 64'(n_got), 64'd5);
        check("drop_last_xy",  64'(got[4][WIDTH-1:WIDTH-6]), 64'(6'o07));
        check("drop_last_pol", 64'(got[4][1:0]), 64'(2'b01));
        check("drop_first_xy", 64'(got[0][WIDTH-1:WIDTH-6]), 64'(6'o01));

        // Timestamp wrap: grants at ts 15 and ts 0.
        do_reset();
        ready = 1'b1;
        for (int t = 0; t < 40 && ts_model != 4'd14; t++) @(negedge clk);
        set_pix(33, 2'b01); set_pix(54, 2'b10);
        @(negedge clk);
        set_in = '0;
        @(negedge clk);
        check("ts_wrap_hi", 64'(data), 64'({6'o41, 4'hF, 2'b01}));
        @(negedge clk);
        check("ts_wrap_lo", 64'(data), 64'({6'o66, 4'h0, 2'b10}));

        // Reset with three events queued discards them.
        @(negedge clk);
        ready = 1'b0;
        set_pix(5, 2'b01); set_pix(6, 2'b01); set_pix(7, 2'b01);
        @(negedge clk);
        set_in = '0;
        repeat (3) @(negedge clk);
        check("mid_queued_valid", 64'(valid), 64'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid",  64'(valid),  64'd0);
        check("mid_rst_active", 64'(active), 64'd0);
        check("mid_rst_full",   64'(full),   64'd0);
        check("mid_rst_data",   64'(data),   64'd0);
        reset_n = 1'b1;
        ready   = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_after_gnt",   64'(gnt),   64'd0);
        check("mid_after_valid", 64'(valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
